vaga_scan_mux: RTL and testbench

// - Parametrised N-channel parking-space sensor scanner; successor of the 4:1 combinational selector.
// - Auto mode: steps a channel counter over all sensors, dwells DWELL cycles per channel, samples the

---
 rtl/vaga_scan_mux_if.sv | 29 ++
 rtl/vaga_scan_mux.sv | 171 +++++++++++++++++
 tb/tb_vaga_scan_mux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vaga_scan_mux_if.sv
// Handshake/bus bundle for the vaga_scan_mux parking-sensor scanner.
// The master drives the controls and sensors; the slave (scanner) drives the results.
interface vaga_scan_mux_if #(
  parameter int N_CH = 8
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int LIV_W = $clog2(N_CH + 1);

  logic             en;
  logic             hold;
  logic             modo;
  logic [SEL_W-1:0] sel_ext;
  logic [N_CH-1:0]  L;
  logic             W;
  logic [SEL_W-1:0] cont;
  logic             valid;
  logic             sweep_done;
  logic [LIV_W-1:0] livres;

  modport master (
    output en, hold, modo, sel_ext, L,
    input  W, cont, valid, sweep_done, livres
  );

  modport slave (
    input  en, hold, modo, sel_ext, L,
    output W, cont, valid, sweep_done, livres
  );
endinterface

// File: rtl/vaga_scan_mux.sv
// N-channel parking sensor scanner: auto sweep with dwell + free count, or manual mux.
// Optional macro SYNC2_EN inserts a 2-flop synchronizer on the sensor inputs.
module vaga_scan_mux #(
  parameter int N_CH  = 8,
  parameter int DWELL = 4
) (
  input logic            clk,
  input logic            rst,
  vaga_scan_mux_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int LIV_W = $clog2(N_CH + 1);
  localparam int DC_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DWELL   = 2'd1;
  localparam logic [1:0] S_AMOSTRA = 2'd2;
  localparam logic [1:0] S_MANUAL  = 2'd3;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DWELL - 1);
  localparam logic [LIV_W-1:0] N_CH_L  = LIV_W'(N_CH);

  logic [N_CH-1:0] l_s;

`ifdef SYNC2_EN
  logic [N_CH-1:0] l_m1_q;
  logic [N_CH-1:0] l_m2_q;

  // two-flop synchronizer in front of every sensor use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_m1_q <= '0;
      l_m2_q <= '0;
    end else begin
      l_m1_q <= bus.L;
      l_m2_q <= l_m1_q;
    end
  end

  assign l_s = l_m2_q;
`else
  assign l_s = bus.L;
`endif

  logic [1:0]       state_q, state_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [SEL_W-1:0] cont_q, cont_d;
  logic [N_CH-1:0]  acc_q, acc_d;
  logic             w_q, w_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [LIV_W-1:0] livres_q, livres_d;

  logic [N_CH-1:0]  acc_new;
  logic             cur_bit;
  logic             man_bit;
  logic [LIV_W-1:0] ones;
  logic [LIV_W-1:0] free_cnt;

  // sample the current channel, fold it into the sweep and count free spaces
  always_comb begin
    acc_new = acc_q;
    cur_bit = 1'b0;
    man_bit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cont_q == SEL_W'(i)) begin
        acc_new[i] = l_s[i];
        cur_bit    = l_s[i];
      end
      if (bus.sel_ext == SEL_W'(i)) begin
        man_bit = l_s[i];
      end
    end
    ones = '0;
    for (int i = 0; i < N_CH; i++) begin
      ones = ones + LIV_W'(acc_new[i]);
    end
    free_cnt = N_CH_L - ones;
  end

  // next state: modo beats en, en beats hold
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    cont_d   = cont_q;
    acc_d    = acc_q;
    w_d      = w_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    livres_d = livres_q;
    if (bus.modo) begin
      state_d = S_MANUAL;
      dcnt_d  = '0;
      acc_d   = '0;
      cont_d  = bus.sel_ext;
      w_d     = man_bit;
    end else if (state_q == S_MANUAL) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
      cont_d  = '0;
    end else if (!bus.en) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
      cont_d  = '0;
      acc_d   = '0;
    end else if (!bus.hold) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          state_d = S_DWELL;
          dcnt_d  = '0;
          cont_d  = '0;
        end
        (state_q == S_DWELL): begin
          if (dcnt_q == DC_LAST) begin
            state_d = S_AMOSTRA;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        (state_q == S_AMOSTRA): begin
          state_d = S_DWELL;
          dcnt_d  = '0;
          w_d     = cur_bit;
          valid_d = 1'b1;
          if (cont_q == LAST_CH) begin
            livres_d = free_cnt;
            done_d   = 1'b1;
            cont_d   = '0;
            acc_d    = '0;
          end else begin
            acc_d  = acc_new;
            cont_d = cont_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dcnt_q   <= '0;
      cont_q   <= '0;
      acc_q    <= '0;
      w_q      <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      livres_q <= '0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      cont_q   <= cont_d;
      acc_q    <= acc_d;
      w_q      <= w_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      livres_q <= livres_d;
    end
  end

  assign bus.W          = w_q;
  assign bus.cont       = cont_q;
  assign bus.valid      = valid_q;
  assign bus.sweep_done = done_q;
  assign bus.livres     = livres_q;
endmodule

// File: tb/tb_vaga_scan_mux.sv
// Directed bench for vaga_scan_mux: auto sweeps, hold, en drop, manual mux, async reset.
// Expected values are hand-derived from the edge timeline of each step.
module tb_vaga_scan_mux;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vaga_scan_mux_if #(.N_CH(8)) bus8 ();
  vaga_scan_mux_if #(.N_CH(6)) bus6 ();

  vaga_scan_mux #(.N_CH(8), .DWELL(4)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  vaga_scan_mux #(.N_CH(6), .DWELL(4)) dut6 (
    .clk(clk),
    .rst(rst),
    .bus(bus6)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sweep(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.sweep_done && n < maxc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] pat;
    rst = 1'b1;
    bus8.en = 1'b0;
    bus8.hold = 1'b0;
    bus8.modo = 1'b0;
    bus8.sel_ext = '0;
    bus8.L = '0;
    bus6.en = 1'b0;
    bus6.hold = 1'b0;
    bus6.modo = 1'b1;
    bus6.sel_ext = '0;
    bus6.L = '0;
    repeat (3) @(negedge clk);
    chk("rst_W", 32'(bus8.W), 0);
    chk("rst_cont", 32'(bus8.cont), 0);
    chk("rst_valid", 32'(bus8.valid), 0);
    chk("rst_done", 32'(bus8.sweep_done), 0);
    chk("rst_livres", 32'(bus8.livres), 0);

    // sweep 1: first posedge after release is edge 0
    rst = 1'b0;
    pat = 8'b1010_0110;
    bus8.L = pat;
    bus8.en = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      chk("s1_valid", 32'(bus8.valid), 32'(i >= 5 && i % 5 == 0));
      chk("s1_done", 32'(bus8.sweep_done), 32'(i == 40));
      if (i >= 5 && i % 5 == 0) begin
        chk("s1_W", 32'(bus8.W), 32'(pat[i/5-1]));
      end
    end
    chk("s1_livres", 32'(bus8.livres), 4);
    chk("s1_cont", 32'(bus8.cont), 0);

    // all occupied, then all free
    bus8.L = 8'hFF;
    wait_sweep(60, n);
    chk("s2_cycles", 32'(n), 40);
    chk("s2_livres", 32'(bus8.livres), 0);
    bus8.L = 8'h00;
    wait_sweep(60, n);
    chk("s3_cycles", 32'(n), 40);
    chk("s3_livres", 32'(bus8.livres), 8);

    // hold for 7 edges inside channel 3 dwell
    bus8.L = 8'h01;
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c >= 18 && c <= 24) begin
        chk("hold_valid", 32'(bus8.valid), 0);
        chk("hold_done", 32'(bus8.sweep_done), 0);
        chk("hold_cont", 32'(bus8.cont), 3);
      end
      if (c == 17) bus8.hold = 1'b1;
      if (c == 24) bus8.hold = 1'b0;
      if (bus8.sweep_done) begin
        n = c;
        break;
      end
    end
    chk("hold_cycles", 32'(n), 47);
    chk("hold_livres", 32'(bus8.livres), 7);

    // drop en during channel 5 dwell
    bus8.L = 8'h30;
    repeat (28) @(negedge clk);
    chk("en_pre_W", 32'(bus8.W), 1);
    chk("en_pre_cont", 32'(bus8.cont), 5);
    bus8.en = 1'b0;
    @(negedge clk);
    chk("en_off_cont", 32'(bus8.cont), 0);
    chk("en_off_valid", 32'(bus8.valid), 0);
    chk("en_off_W", 32'(bus8.W), 1);
    chk("en_off_livres", 32'(bus8.livres), 7);
    bus8.en = 1'b1;
    wait_sweep(60, n);
    chk("en_restart_cycles", 32'(n), 41);
    chk("en_restart_livres", 32'(bus8.livres), 6);

    // manual select
    bus8.L = 8'b0100_0100;
    bus8.modo = 1'b1;
    bus8.sel_ext = 3'd2;
    @(negedge clk);
    chk("man2_W", 32'(bus8.W), 1);
    chk("man2_cont", 32'(bus8.cont), 2);
    chk("man2_valid", 32'(bus8.valid), 0);
    bus8.sel_ext = 3'd6;
    @(negedge clk);
    chk("man6_W", 32'(bus8.W), 1);
    chk("man6_cont", 32'(bus8.cont), 6);
    chk("man6_done", 32'(bus8.sweep_done), 0);
    bus8.sel_ext = 3'd3;
    @(negedge clk);
    chk("man3_W", 32'(bus8.W), 0);
    chk("man_livres", 32'(bus8.livres), 6);

    // back to auto: IDLE one edge, then scan from channel 0
    bus8.L = 8'h45;
    bus8.modo = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.valid && n < 20);
    chk("ret_cycles", 32'(n), 7);
    chk("ret_W", 32'(bus8.W), 1);
    chk("ret_cont", 32'(bus8.cont), 1);

    // async reset while in the sample state
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_W", 32'(bus8.W), 0);
    chk("arst_cont", 32'(bus8.cont), 0);
    chk("arst_valid", 32'(bus8.valid), 0);
    chk("arst_done", 32'(bus8.sweep_done), 0);
    chk("arst_livres", 32'(bus8.livres), 0);

    // 6-channel instance: out-of-range select gives 0
    @(negedge clk);
    rst = 1'b0;
    bus6.L = 6'b10_0000;
    bus6.sel_ext = 3'd5;
    @(negedge clk);
    chk("n6_sel5_W", 32'(bus6.W), 1);
    chk("n6_sel5_cont", 32'(bus6.cont), 5);
    bus6.sel_ext = 3'd7;
    @(negedge clk);
    chk("n6_sel7_W", 32'(bus6.W), 0);
    chk("n6_sel7_cont", 32'(bus6.cont), 7);
    chk("n6_valid", 32'(bus6.valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
